// File: rtl/rd_fwft_pkg.sv
// Shared read-side FIFO types: occupancy state encoding and data width default.
package rd_fwft_pkg;

    localparam int FIFO_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        S_ZERO = 2'd0,
        S_ONE  = 2'd1,
        S_TWO  = 2'd2
    } occ_t;

    function automatic logic [2:0] occ_count(input occ_t s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/rd_fwft.sv
// First-word-fall-through adapter for a 1-cycle-latency FIFO read port.
// Define RD_FWFT_POPCNT_EN to build the pop statistics counter.
module rd_fwft
    import rd_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CNT_WIDTH-1:0]  pop_cnt
);

    occ_t                  state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic                  valid_q, valid_d;
    logic                  run_q, run_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  pop;
    logic [2:0]            need;

    assign pop  = valid_q & dout_ready;
    assign need = occ_count(state_q) + {2'b0, inflight_q} - {2'b0, pop};

    // run_q keeps rd_en low until the first edge after reset release
    assign rd_en      = run_q & ~empty & (need < 3'd2);
    assign dout       = head_q;
    assign dout_valid = valid_q;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        inflight_d = rd_en;
        run_d      = 1'b1;
        unique case (state_q)
            S_ZERO: begin
                if (inflight_q) begin
                    head_d  = rd_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (inflight_q && pop) begin
                    head_d = rd_data;
                end else if (inflight_q) begin
                    skid_d  = rd_data;
                    state_d = S_TWO;
                end else if (pop) begin
                    state_d = S_ZERO;
                end
            end
            S_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    if (inflight_q) begin
                        skid_d = rd_data;
                    end else begin
                        state_d = S_ONE;
                    end
                end
            end
            default: begin
                state_d = S_ZERO;
            end
        endcase
        valid_d = (state_d != S_ZERO);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q    <= S_ZERO;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            run_q      <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            run_q      <= run_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

`ifdef RD_FWFT_POPCNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pop_cnt = cnt_q;
`else
    assign pop_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_fwft.sv
// Self-checking bench for rd_fwft: FIFO source model plus held-word queue model.
module tb_rd_fwft;
    import rd_fwft_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          empty = 1'b1;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [CW-1:0] pop_cnt;

    always #5 rd_clk = ~rd_clk;

    rd_fwft #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .empty     (empty),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .pop_cnt   (pop_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] hq[$];
    bit            pend_v;
    logic [DW-1:0] pend_w;
    bit            prev_hold;
    logic [DW-1:0] prev_dout;
    int            pops;
    int            cyc;
    int            ph_pops;
    int            ph_rden;
    int            first_rd;
    int            first_v;
    int            last_v;
    int            vcount;
    logic [DW-1:0] first_word;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef RD_FWFT_POPCNT_EN
        return 32'(pops % (1 << CW));
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_stats();
        ph_pops  = 0;
        ph_rden  = 0;
        first_rd = -1;
        first_v  = -1;
        last_v   = -1;
        vcount   = 0;
    endtask

    task automatic step(input bit rdy);
        bit popped;
        @(negedge rd_clk);
        rd_data    = pend_v ? pend_w : DW'($urandom);
        empty      = (src.size() == 0);
        dout_ready = rdy;
        #1;
        cyc++;
        chk("rd_en_while_empty", 32'(rd_en && empty), 0);
        chk("valid", 32'(dout_valid), 32'(hq.size() != 0));
        chk("occ_bound", 32'(hq.size() <= 2), 1);
        if (hq.size() != 0) chk("dout", 32'(dout), 32'(hq[0]));
        if (prev_hold) chk("stall_hold", 32'(dout), 32'(prev_dout));
        chk("pop_cnt", 32'(pop_cnt), exp_cnt());
        if (rd_en) begin
            ph_rden++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (dout_valid) begin
            vcount++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        popped    = dout_valid && rdy && (hq.size() != 0);
        prev_hold = dout_valid && !rdy;
        prev_dout = dout;
        if (popped) begin
            if (ph_pops == 0) first_word = hq[0];
            void'(hq.pop_front());
            pops++;
            ph_pops++;
        end
        if (pend_v) hq.push_back(pend_w);
        pend_v = rd_en && (src.size() != 0);
        if (pend_v) pend_w = src.pop_front();
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst_n = 1'b0;
        empty    = 1'b1;
        #1;
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_pop_cnt", 32'(pop_cnt), 0);
        hq.delete();
        pend_v    = 1'b0;
        prev_hold = 1'b0;
        pops      = 0;
        @(negedge rd_clk);
        rd_rst_n   = 1'b1;
        empty      = (src.size() == 0);
        dout_ready = 1'b1;
        #1;
        chk("release_rd_en", 32'(rd_en), 0);
        chk("release_valid", 32'(dout_valid), 0);
    endtask

    initial begin
        int n;
        cyc = 0;
        pend_v = 1'b0;
        prev_hold = 1'b0;
        pops = 0;
        first_word = '0;
        clear_stats();

        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("idle_rden", 32'(ph_rden), 0);

        clear_stats();
        for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
        for (int i = 0; i < 14; i++) step(1'b1);
        chk("latency", 32'(first_v - first_rd), 2);
        chk("burst_valid_cycles", 32'(vcount), 8);
        chk("burst_no_gap", 32'(last_v - first_v), 7);
        chk("burst_pops", 32'(ph_pops), 8);
        chk("burst_pop_cnt", 32'(pop_cnt), exp_cnt());

        clear_stats();
        for (int i = 0; i < 4; i++) src.push_back(DW'(16'h0a0 + i));
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("bp_rden_count", 32'(ph_rden), 2);
        chk("bp_state", 32'(dut.state_q), 32'(S_TWO));
        chk("bp_head", 32'(dout), 32'h0a0);
        clear_stats();
        for (int i = 0; i < 8; i++) step(1'b1);
        chk("bp_drain_pops", 32'(ph_pops), 4);
        chk("bp_drain_no_gap", 32'(last_v - first_v), 3);
        chk("bp_first", 32'(first_word), 32'h0a0);

        for (int i = 0; i < 6; i++) src.push_back(DW'(16'h100 + i));
        step(1'b0);
        step(1'b0);
        do_reset();
        clear_stats();
        for (int i = 0; i < 12; i++) step(1'b1);
        chk("rst_resume_first", 32'(first_word), 32'h102);
        chk("rst_resume_pops", 32'(ph_pops), 4);

        do_reset();
        clear_stats();
        for (int i = 0; i < 17; i++) src.push_back(DW'(16'h200 + i));
        n = 0;
        while (ph_pops < 17 && n < 100) begin
            step(1'b1);
            n++;
        end
        chk("wrap_pops", 32'(ph_pops), 17);
`ifdef RD_FWFT_POPCNT_EN
        chk("wrap_pop_cnt", 32'(pop_cnt), 1);
`else
        chk("wrap_pop_cnt", 32'(pop_cnt), 0);
`endif

        clear_stats();
        n = 0;
        for (int pushed = 0, c = 0; c < 10000 && ph_pops < 1000; c++) begin
            if (pushed < 1000 && $urandom_range(0, 9) < 7) begin
                src.push_back(DW'($urandom));
                pushed++;
            end
            step(1'($urandom_range(0, 1)));
        end
        chk("rand_delivered", 32'(ph_pops), 1000);
        chk("rand_src_drained", 32'(src.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rd_fwft.md
RD_FWFT -- requirements
Module: rd_fwft

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the FIFO data word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the pop statistics counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: rd_clk  input  1  read-domain clock.
REQ-004 rd_rst_n  input  1  asynchronous active-low reset.
REQ-005 empty  input  1  FIFO empty flag from the read-pointer stage.
REQ-006 rd_en  output  1  read request to the read-pointer stage; one memory word read per asserted cycle.
REQ-007 rd_data  input  DATA_WIDTH  memory read data, valid exactly 1 cycle after an accepted rd_en.
REQ-008 dout  output  DATA_WIDTH  head-of-queue word in first-word-fall-through form.
REQ-009 dout_valid  output  1  dout holds a valid word.
REQ-010 dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 pop_cnt  output  CNT_WIDTH  count of words delivered to the consumer.

Function
REQ-012 SHALL convert the 1-cycle-latency FIFO read port into a valid/ready FWFT stream using a 2-entry buffer: a head register (drives dout) and a skid register.
REQ-013 SHALL track occupancy with states S_ZERO, S_ONE and S_TWO, plus a registered inflight flag set in the cycle after rd_en is asserted.
REQ-014 pop SHALL equal dout_valid && dout_ready; dout_valid SHALL be registered and equal (state != S_ZERO).
REQ-015 rd_en SHALL equal !empty && (occ + inflight - pop < 2), where occ is 0, 1 or 2; the combinational path from dout_ready to rd_en is permitted.
REQ-016 On arrival (inflight=1), the arriving rd_data SHALL load head if occ=0, or if occ=1 with pop.
REQ-017 On arrival with occ=1 and no pop, rd_data SHALL load skid.
REQ-018 On arrival with occ=2 and pop, skid SHALL move to head and rd_data SHALL load skid.
REQ-019 On pop with no arrival and occ=2, skid SHALL move to head and the state SHALL go to S_ONE.
REQ-020 On pop with no arrival and occ=1, the state SHALL go to S_ZERO.
REQ-021 State transitions SHALL be: next occ = occ + inflight - pop; arrival with occ=2 and no pop SHALL be unreachable by construction (REQ-015).
REQ-022 dout SHALL hold its value while dout_valid && !dout_ready (no change under backpressure).
REQ-023 First-word latency SHALL be 2 cycles from empty deasserting: rd_en in cycle t, dout_valid in cycle t+2.
REQ-024 Sustained throughput SHALL be 1 word/cycle while !empty and dout_ready=1.
REQ-025 Order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-026 dout_ready while dout_valid=0 SHALL be ignored.

Reset
REQ-027 While rd_rst_n=0: state=S_ZERO, inflight=0, dout=0, dout_valid=0, pop_cnt=0, and rd_en=0 combinationally.
REQ-028 Reset asserted mid-operation SHALL discard the head, skid and in-flight data; the first rd_en after release SHALL occur no earlier than the first rd_clk edge after release.

Configuration
REQ-029 Macro RD_FWFT_POPCNT_EN SHALL control the statistics counter.
REQ-030 With RD_FWFT_POPCNT_EN defined, pop_cnt SHALL increment by 1 on every pop and wrap modulo 2^CNT_WIDTH.
REQ-031 Without RD_FWFT_POPCNT_EN, pop_cnt SHALL be tied to 0 and no counter flops SHALL be inferred; the port list SHALL be unchanged.

Structure
REQ-032 The shared FIFO package SHALL hold the occupancy state typedef (S_ZERO, S_ONE, S_TWO) and the DATA_WIDTH default.
REQ-033 No sub-module SHALL be used; the block is a single module instantiated between the read-pointer stage and the consumer.

Verification
REQ-034 Reset release with empty=1 and dout_ready=1 -> rd_en=0, dout_valid=0, pop_cnt=0 for 10 cycles.
REQ-035 Write 0x0001..0x0008, hold dout_ready=1 -> first dout_valid 2 cycles after empty falls, then 0x0001..0x0008 on consecutive cycles, pop_cnt=8.
REQ-036 Preload 4 words, dout_ready=0 for 6 cycles -> rd_en asserted exactly 2 times, dout=word0 stable, state=S_TWO; then dout_ready=1 -> words 0..3 in order with no gaps.
REQ-037 Random dout_ready at 50% over 1000 words -> scoreboard matches in order, and rd_en is never asserted with empty=1.
REQ-038 Assert rd_rst_n=0 for 1 cycle with S_TWO and inflight=1 -> dout_valid=0 next cycle, then the stream resumes from the FIFO's next unread word.
REQ-039 With RD_FWFT_POPCNT_EN and CNT_WIDTH=4, pop 17 words -> pop_cnt=1 (wrap); without the macro -> pop_cnt=0 throughout.
